// File: rtl/stereo_pkg.sv
// Shared types and helpers for the stereo fold datapath.
package stereo_pkg;

   typedef enum logic {S_LEFT, S_RIGHT} fold_state_t;

   function automatic int unsigned beats_w(input int unsigned width, input int unsigned ppc);
      return width / ppc;
   endfunction

endpackage

// File: rtl/stereo_line_fifo.sv
// Synchronous FIFO holding one line of right-view beats; read data is fall-through so the
// consumer's register stage captures it on the read cycle.
module stereo_line_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned DW    = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          wr_en_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          rd_en_i,
   output logic [DW-1:0] rd_data_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_fire, rd_fire;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign wr_fire   = wr_en_i && !full_o;
   assign rd_fire   = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_fire ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = rd_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      unique case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/stereo_fold.sv
// Merges left and right AXI4-Stream views into one side-by-side stream: each output line is
// LINE_BEATS left beats followed by LINE_BEATS right beats replayed from a one-line FIFO.
module stereo_fold
   import stereo_pkg::*;
#(
   parameter int unsigned WIDTH                 = 3840,
   parameter int unsigned HEIGHT                = 2160,
   parameter int unsigned MAX_SAMPLES_PER_CLOCK = 4,
   parameter int unsigned DATA_WIDTH            = 8,
   parameter int unsigned AXIS_TDATA_WIDTH      = 32
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_l_tdata,
   input  logic                        s_axis_l_tvalid,
   input  logic                        s_axis_l_tuser,
   input  logic                        s_axis_l_tlast,
   output logic                        s_axis_l_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_r_tdata,
   input  logic                        s_axis_r_tvalid,
   input  logic                        s_axis_r_tuser,
   input  logic                        s_axis_r_tlast,
   output logic                        s_axis_r_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_lr_tdata,
   output logic                        m_axis_lr_tvalid,
   output logic                        m_axis_lr_tuser,
   output logic                        m_axis_lr_tlast,
   input  logic                        m_axis_lr_tready,
   output logic                        line_err
);

   localparam int unsigned LINE_BEATS = beats_w(WIDTH, MAX_SAMPLES_PER_CLOCK);
   localparam int unsigned CW         = $clog2(LINE_BEATS + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_BEATS - 1);
   // An inconsistent configuration never raises a ready, so nothing flows.
   localparam bit PARAMS_OK = (WIDTH % MAX_SAMPLES_PER_CLOCK == 0) && (HEIGHT > 0) &&
                              (AXIS_TDATA_WIDTH == DATA_WIDTH * MAX_SAMPLES_PER_CLOCK);

   fold_state_t                 state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d, rcnt_q, rcnt_d;
   logic                        rdy_en_q;
   logic                        m_tvalid_q, m_tvalid_d, m_tuser_q, m_tuser_d, m_tlast_q, m_tlast_d;
   logic [AXIS_TDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
   logic                        line_err_q, line_err_d;
   logic                        slice_free, l_acc, l_ready, fifo_rd, r_wr;
   logic                        fifo_full, fifo_empty;
   logic [AXIS_TDATA_WIDTH-1:0] fifo_rdata;

   assign slice_free      = !m_tvalid_q || m_axis_lr_tready;
   assign s_axis_r_tready = rdy_en_q && !fifo_full;
   assign r_wr            = s_axis_r_tvalid && s_axis_r_tready;
   assign s_axis_l_tready = l_ready;

   stereo_line_fifo #(
      .DEPTH (LINE_BEATS),
      .DW    (AXIS_TDATA_WIDTH)
   ) u_fifo (
      .clk_i     (aclk),
      .rst_ni    (aresetn),
      .wr_en_i   (r_wr),
      .wr_data_i (s_axis_r_tdata),
      .rd_en_i   (fifo_rd),
      .rd_data_o (fifo_rdata),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_LEFT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (l_acc || fifo_rd) begin
         if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = (state_q == S_LEFT) ? S_RIGHT : S_LEFT;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      l_ready = 1'b0;
      l_acc   = 1'b0;
      fifo_rd = 1'b0;
      unique case (state_q)
         S_LEFT: begin
            l_ready = rdy_en_q && slice_free;
            l_acc   = l_ready && s_axis_l_tvalid;
         end
         S_RIGHT: fifo_rd = rdy_en_q && slice_free && !fifo_empty;
         default: ;
      endcase
   end

   always_comb begin
      m_tvalid_d = m_tvalid_q;
      m_tuser_d  = m_tuser_q;
      m_tlast_d  = m_tlast_q;
      m_tdata_d  = m_tdata_q;
      if (slice_free) begin
         m_tvalid_d = l_acc || fifo_rd;
         if (l_acc) begin
            m_tdata_d = s_axis_l_tdata;
            m_tuser_d = s_axis_l_tuser;
            m_tlast_d = 1'b0;
         end else if (fifo_rd) begin
            m_tdata_d = fifo_rdata;
            m_tuser_d = 1'b0;
            m_tlast_d = (cnt_q == LAST_BEAT);
         end
      end
   end

   // The right view keeps its own write-side beat position for framing checks.
   always_comb begin
      rcnt_d = rcnt_q;
      if (r_wr) rcnt_d = (rcnt_q == LAST_BEAT) ? '0 : rcnt_q + 1'b1;
      line_err_d =
         (l_acc && ((s_axis_l_tlast != (cnt_q == LAST_BEAT)) || (s_axis_l_tuser && cnt_q != '0))) ||
         (r_wr && ((s_axis_r_tlast != (rcnt_q == LAST_BEAT)) || (s_axis_r_tuser && rcnt_q != '0)));
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rdy_en_q   <= 1'b0;
         rcnt_q     <= '0;
         line_err_q <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tuser_q  <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tdata_q  <= '0;
      end else begin
         rdy_en_q   <= PARAMS_OK;
         rcnt_q     <= rcnt_d;
         line_err_q <= line_err_d;
         m_tvalid_q <= m_tvalid_d;
         m_tuser_q  <= m_tuser_d;
         m_tlast_q  <= m_tlast_d;
         m_tdata_q  <= m_tdata_d;
      end
   end

   assign m_axis_lr_tvalid = m_tvalid_q;
   assign m_axis_lr_tuser  = m_tuser_q;
   assign m_axis_lr_tlast  = m_tlast_q;
   assign m_axis_lr_tdata  = m_tdata_q;
   assign line_err         = line_err_q;

endmodule

// File: tb/tb_stereo_fold.sv
// Directed bench for stereo_fold with LINE_BEATS = 2 (WIDTH 8, 4 pixels per beat).
module tb_stereo_fold;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] l_tdata, r_tdata, m_tdata;
   logic        l_tvalid, l_tuser, l_tlast, l_tready;
   logic        r_tvalid, r_tuser, r_tlast, r_tready;
   logic        m_tvalid, m_tuser, m_tlast, m_tready;
   logic        line_err;
   logic        tog = 1'b0;
   logic        toggle_mode, hold_ready;

   int          compared   = 0;
   int          mismatched = 0;
   int          err_cycles = 0;
   logic [33:0] outq[$];

   always #5 aclk = ~aclk;
   always @(posedge aclk) tog <= ~tog;
   assign m_tready = toggle_mode ? tog : hold_ready;

   stereo_fold #(
      .WIDTH                 (8),
      .HEIGHT                (4),
      .MAX_SAMPLES_PER_CLOCK (4),
      .DATA_WIDTH            (8),
      .AXIS_TDATA_WIDTH      (32)
   ) dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .s_axis_l_tdata   (l_tdata),
      .s_axis_l_tvalid  (l_tvalid),
      .s_axis_l_tuser   (l_tuser),
      .s_axis_l_tlast   (l_tlast),
      .s_axis_l_tready  (l_tready),
      .s_axis_r_tdata   (r_tdata),
      .s_axis_r_tvalid  (r_tvalid),
      .s_axis_r_tuser   (r_tuser),
      .s_axis_r_tlast   (r_tlast),
      .s_axis_r_tready  (r_tready),
      .m_axis_lr_tdata  (m_tdata),
      .m_axis_lr_tvalid (m_tvalid),
      .m_axis_lr_tuser  (m_tuser),
      .m_axis_lr_tlast  (m_tlast),
      .m_axis_lr_tready (m_tready),
      .line_err         (line_err)
   );

   // Records every beat that will transfer on the coming rising edge.
   always @(negedge aclk) begin
      if (aresetn && m_tvalid && m_tready) outq.push_back({m_tuser, m_tlast, m_tdata});
      if (line_err) err_cycles++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed running, expected done");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_l(input logic [31:0] d, input logic u, input logic t);
      logic rdy = 1'b0;
      int   n   = 0;
      l_tdata = d; l_tuser = u; l_tlast = t; l_tvalid = 1'b1;
      while (!rdy && n < 200) begin
         @(negedge aclk); rdy = l_tready;
         @(posedge aclk); #1; n++;
      end
      l_tvalid = 1'b0; l_tuser = 1'b0; l_tlast = 1'b0;
      check($sformatf("l_accept_%0h", d), 64'(rdy), 64'd1);
   endtask

   task automatic send_r(input logic [31:0] d, input logic u, input logic t);
      logic rdy = 1'b0;
      int   n   = 0;
      r_tdata = d; r_tuser = u; r_tlast = t; r_tvalid = 1'b1;
      while (!rdy && n < 200) begin
         @(negedge aclk); rdy = r_tready;
         @(posedge aclk); #1; n++;
      end
      r_tvalid = 1'b0; r_tuser = 1'b0; r_tlast = 1'b0;
      check($sformatf("r_accept_%0h", d), 64'(rdy), 64'd1);
   endtask

   task automatic wait_out(input int n, input string tag);
      int k = 0;
      while (outq.size() < n && k < 300) begin
         @(posedge aclk); #1; k++;
      end
      repeat (4) begin @(posedge aclk); #1; end
      check({tag, "_count"}, 64'(outq.size()), 64'(n));
   endtask

   task automatic check_beat(input string tag, input int idx, input logic u, input logic t,
                             input logic [31:0] d);
      logic [33:0] got;
      got = (idx < outq.size()) ? outq[idx] : '1;
      check($sformatf("%s_beat%0d", tag, idx), 64'(got), 64'({u, t, d}));
   endtask

   initial begin
      logic [31:0] dl, dr;
      aresetn = 1'b0; toggle_mode = 1'b0; hold_ready = 1'b1;
      l_tdata = '0; l_tvalid = 1'b0; l_tuser = 1'b0; l_tlast = 1'b0;
      r_tdata = '0; r_tvalid = 1'b0; r_tuser = 1'b0; r_tlast = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("reset_ctrl", 64'({m_tvalid, m_tuser, m_tlast, l_tready, r_tready, line_err}), 64'd0);
      check("reset_data", 64'(m_tdata), 64'd0);
      @(posedge aclk); #1; aresetn = 1'b1;
      repeat (2) begin @(posedge aclk); #1; end

      // Basic line: left then right.
      outq.delete(); err_cycles = 0;
      send_l(32'hAAAA_0000, 1'b1, 1'b0);
      send_l(32'hAAAA_0001, 1'b0, 1'b1);
      send_r(32'hBBBB_0000, 1'b1, 1'b0);
      send_r(32'hBBBB_0001, 1'b0, 1'b1);
      wait_out(4, "t1");
      check_beat("t1", 0, 1'b1, 1'b0, 32'hAAAA_0000);
      check_beat("t1", 1, 1'b0, 1'b0, 32'hAAAA_0001);
      check_beat("t1", 2, 1'b0, 1'b0, 32'hBBBB_0000);
      check_beat("t1", 3, 1'b0, 1'b1, 32'hBBBB_0001);
      check("t1_line_err", 64'(err_cycles), 64'd0);

      // Right view runs a full line ahead, then fills the FIFO.
      outq.delete(); err_cycles = 0;
      send_r(32'h2000_0000, 1'b0, 1'b0);
      send_r(32'h2000_0001, 1'b0, 1'b1);
      @(negedge aclk);
      check("t2_r_full", 64'(r_tready), 64'd0);
      @(posedge aclk); #1;
      fork
         begin
            send_l(32'h1000_0000, 1'b0, 1'b0); send_l(32'h1000_0001, 1'b0, 1'b1);
            send_l(32'h1100_0000, 1'b0, 1'b0); send_l(32'h1100_0001, 1'b0, 1'b1);
         end
         begin
            send_r(32'h2100_0000, 1'b0, 1'b0); send_r(32'h2100_0001, 1'b0, 1'b1);
         end
      join
      wait_out(8, "t2");
      check_beat("t2", 0, 1'b0, 1'b0, 32'h1000_0000);
      check_beat("t2", 1, 1'b0, 1'b0, 32'h1000_0001);
      check_beat("t2", 2, 1'b0, 1'b0, 32'h2000_0000);
      check_beat("t2", 3, 1'b0, 1'b1, 32'h2000_0001);
      check_beat("t2", 4, 1'b0, 1'b0, 32'h1100_0000);
      check_beat("t2", 5, 1'b0, 1'b0, 32'h1100_0001);
      check_beat("t2", 6, 1'b0, 1'b0, 32'h2100_0000);
      check_beat("t2", 7, 1'b0, 1'b1, 32'h2100_0001);
      check("t2_line_err", 64'(err_cycles), 64'd0);

      // Output ready toggling every cycle over three lines.
      outq.delete(); err_cycles = 0; toggle_mode = 1'b1;
      fork
         for (int i = 0; i < 6; i++) send_l(32'h3000_0000 + i, (i == 0), (i % 2 == 1));
         for (int j = 0; j < 6; j++) send_r(32'h4000_0000 + j, (j == 0), (j % 2 == 1));
      join
      wait_out(12, "t3");
      toggle_mode = 1'b0;
      for (int ln = 0; ln < 3; ln++) begin
         for (int b = 0; b < 2; b++) begin
            dl = 32'h3000_0000 + 32'(2 * ln + b);
            dr = 32'h4000_0000 + 32'(2 * ln + b);
            check_beat("t3", 4 * ln + b, (ln == 0 && b == 0), 1'b0, dl);
            check_beat("t3", 4 * ln + 2 + b, 1'b0, (b == 1), dr);
         end
      end
      check("t3_line_err", 64'(err_cycles), 64'd0);

      // Early tlast on the first left beat.
      outq.delete(); err_cycles = 0;
      send_l(32'h5000_0000, 1'b0, 1'b1);
      send_l(32'h5000_0001, 1'b0, 1'b1);
      send_r(32'h6000_0000, 1'b0, 1'b0);
      send_r(32'h6000_0001, 1'b0, 1'b1);
      wait_out(4, "t4");
      check_beat("t4", 0, 1'b0, 1'b0, 32'h5000_0000);
      check_beat("t4", 1, 1'b0, 1'b0, 32'h5000_0001);
      check_beat("t4", 2, 1'b0, 1'b0, 32'h6000_0000);
      check_beat("t4", 3, 1'b0, 1'b1, 32'h6000_0001);
      check("t4_line_err_cycles", 64'(err_cycles), 64'd1);

      // Reset in the middle of the right half discards the partial line.
      outq.delete();
      send_l(32'h7000_0000, 1'b1, 1'b0);
      send_l(32'h7000_0001, 1'b0, 1'b1);
      send_r(32'h8000_0000, 1'b0, 1'b0);
      repeat (4) begin @(posedge aclk); #1; end
      check("t5_pre_count", 64'(outq.size()), 64'd3);
      aresetn = 1'b0;
      @(negedge aclk);
      check("t5_rst_ctrl", 64'({m_tvalid, m_tuser, m_tlast, l_tready, r_tready, line_err}), 64'd0);
      check("t5_rst_data", 64'(m_tdata), 64'd0);
      @(posedge aclk); #1; aresetn = 1'b1;
      outq.delete(); err_cycles = 0;
      send_l(32'h9000_0000, 1'b1, 1'b0);
      send_l(32'h9000_0001, 1'b0, 1'b1);
      send_r(32'h9100_0000, 1'b1, 1'b0);
      send_r(32'h9100_0001, 1'b0, 1'b1);
      wait_out(4, "t5");
      check_beat("t5", 0, 1'b1, 1'b0, 32'h9000_0000);
      check_beat("t5", 1, 1'b0, 1'b0, 32'h9000_0001);
      check_beat("t5", 2, 1'b0, 1'b0, 32'h9100_0000);
      check_beat("t5", 3, 1'b0, 1'b1, 32'h9100_0001);
      check("t5_line_err", 64'(err_cycles), 64'd0);

      // Right view idle while the fold waits in the right half.
      outq.delete();
      send_l(32'hC000_0000, 1'b1, 1'b0);
      send_l(32'hC000_0001, 1'b0, 1'b1);
      @(posedge aclk); #1;
      for (int c = 0; c < 5; c++) begin
         @(negedge aclk);
         check($sformatf("t6_idle_valid%0d", c), 64'(m_tvalid), 64'd0);
         @(posedge aclk); #1;
      end
      send_r(32'hD000_0000, 1'b1, 1'b0);
      send_r(32'hD000_0001, 1'b0, 1'b1);
      wait_out(4, "t6");
      check_beat("t6", 0, 1'b1, 1'b0, 32'hC000_0000);
      check_beat("t6", 1, 1'b0, 1'b0, 32'hC000_0001);
      check_beat("t6", 2, 1'b0, 1'b0, 32'hD000_0000);
      check_beat("t6", 3, 1'b0, 1'b1, 32'hD000_0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
